// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer_bank multi-channel countdown timer.
// Holds the per-channel FSM state encoding used by timer_channel.
package timer_bank_pkg;

    typedef enum logic [1:0] {
        TB_IDLE     = 2'd0,
        TB_COUNTING = 2'd1,
        TB_PAUSED   = 2'd2,
        TB_EXPIRED  = 2'd3
    } tb_state_e;

endpackage : timer_bank_pkg

// File: rtl/timer_channel.sv
// One countdown channel of timer_bank: a four-state FSM plus a CNT_W-bit
// down counter.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   tick               shared 1-cycle decrement enable
//   start              start/restart pulse, loads load_value
//   pause              level, freezes a counting channel
//   abort              pulse, returns the channel to IDLE
//   auto_reload        level, sampled in EXPIRED to re-arm the channel
//   load_value         reload value
//   expired            1-cycle pulse while in EXPIRED
//   busy               1 while COUNTING or PAUSED
//   count              live counter value
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             auto_reload,
    input  logic [CNT_W-1:0] load_value,
    output logic             expired,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    tb_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TB_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic; priority abort > start > pause > tick
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            TB_IDLE: begin
                count_d = '0;
                if (!abort && start) begin
                    state_d = TB_COUNTING;
                    count_d = load_value;
                end
            end
            TB_COUNTING: begin
                if (abort) begin
                    state_d = TB_IDLE;
                    count_d = '0;
                end else if (start) begin
                    count_d = load_value;
                end else if (pause) begin
                    state_d = TB_PAUSED;
                end else if (count_q == '0) begin
                    // Leaving COUNTING here is what keeps the decrement from wrapping
                    state_d = TB_EXPIRED;
                end else if (tick) begin
                    count_d = count_q - CNT_ONE;
                end
            end
            TB_PAUSED: begin
                // Ticks arriving while paused are dropped, not queued
                if (abort) begin
                    state_d = TB_IDLE;
                    count_d = '0;
                end else if (start) begin
                    state_d = TB_COUNTING;
                    count_d = load_value;
                end else if (!pause) begin
                    state_d = TB_COUNTING;
                end
            end
            TB_EXPIRED: begin
                count_d = '0;
                if (abort) begin
                    state_d = TB_IDLE;
                end else if (start || auto_reload) begin
                    state_d = TB_COUNTING;
                    count_d = load_value;
                end else begin
                    state_d = TB_IDLE;
                end
            end
            default: begin
                state_d = TB_IDLE;
                count_d = '0;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        expired = (state_q == TB_EXPIRED);
        busy    = (state_q == TB_COUNTING) || (state_q == TB_PAUSED);
        count   = count_q;
    end

endmodule : timer_channel

// File: rtl/timer_bank.sv
// timer_bank: NUM_CH independent countdown timers sharing one tick enable.
// Each channel supports start/restart, pause/resume, abort and auto-reload.
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   tick          shared 1-cycle decrement enable
//   start         per-channel start/restart pulse
//   pause         per-channel pause level
//   abort         per-channel abort pulse
//   auto_reload   per-channel re-arm level, sampled at expiry
//   load_value    channel i at [i*CNT_W +: CNT_W]
//   expired       per-channel 1-cycle expiry pulse
//   busy          per-channel COUNTING|PAUSED indicator
//   count         live counters, same packing as load_value
//   any_expired   OR of expired, same cycle
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       pause,
    input  logic [NUM_CH-1:0]       abort,
    input  logic [NUM_CH-1:0]       auto_reload,
    input  logic [NUM_CH*CNT_W-1:0] load_value,
    output logic [NUM_CH-1:0]       expired,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic                    any_expired
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .tick        (tick),
            .start       (start[i]),
            .pause       (pause[i]),
            .abort       (abort[i]),
            .auto_reload (auto_reload[i]),
            .load_value  (load_value[i*CNT_W +: CNT_W]),
            .expired     (expired[i]),
            .busy        (busy[i]),
            .count       (count[i*CNT_W +: CNT_W])
        );
    end

    always_comb begin
        any_expired = |expired;
    end

endmodule : timer_bank

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    tick;
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       pause;
    logic [NUM_CH-1:0]       abort;
    logic [NUM_CH-1:0]       auto_reload;
    logic [NUM_CH*CNT_W-1:0] load_value;
    logic [NUM_CH-1:0]       expired;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH*CNT_W-1:0] count;
    logic                    any_expired;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: a channel is either running (active, possibly frozen),
    // in its single expiry cycle (expiring), or doing nothing.
    int m_cnt      [NUM_CH];
    bit m_active   [NUM_CH];
    bit m_frozen   [NUM_CH];
    bit m_expiring [NUM_CH];

    always #5 clk = ~clk;

    timer_bank #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .start       (start),
        .pause       (pause),
        .abort       (abort),
        .auto_reload (auto_reload),
        .load_value  (load_value),
        .expired     (expired),
        .busy        (busy),
        .count       (count),
        .any_expired (any_expired)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int load_of(input int ch);
        return int'(load_value[ch*CNT_W +: CNT_W]);
    endfunction

    function automatic int cnt_of(input int ch);
        return int'(count[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic set_load(input int ch, input int val);
        load_value[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                m_cnt[c] = 0; m_active[c] = 0; m_frozen[c] = 0; m_expiring[c] = 0;
            end else if (m_expiring[c]) begin
                m_expiring[c] = 0;
                if (!abort[c] && (start[c] || auto_reload[c])) begin
                    m_active[c] = 1; m_frozen[c] = 0; m_cnt[c] = load_of(c);
                end
            end else if (m_active[c]) begin
                if (abort[c]) begin
                    m_active[c] = 0; m_frozen[c] = 0; m_cnt[c] = 0;
                end else if (start[c]) begin
                    m_frozen[c] = 0; m_cnt[c] = load_of(c);
                end else if (m_frozen[c]) begin
                    m_frozen[c] = pause[c];
                end else if (pause[c]) begin
                    m_frozen[c] = 1;
                end else if (m_cnt[c] == 0) begin
                    m_active[c] = 0; m_expiring[c] = 1;
                end else if (tick) begin
                    m_cnt[c] = m_cnt[c] - 1;
                end
            end else if (!abort[c] && start[c]) begin
                m_active[c] = 1; m_cnt[c] = load_of(c);
            end
        end
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0]       e_exp, e_busy;
        logic [NUM_CH*CNT_W-1:0] e_cnt;
        e_exp = '0; e_busy = '0; e_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            e_exp[c]  = m_expiring[c];
            e_busy[c] = m_active[c];
            e_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        end
        check("model_expired", 32'(expired), 32'(e_exp));
        check("model_busy", 32'(busy), 32'(e_busy));
        check("model_count", 32'(count), 32'(e_cnt));
        check("model_any_expired", 32'(any_expired), 32'(|e_exp));
    endtask

    // Inputs are driven at the negedge; DUT and model both consume them at the posedge
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_inputs();
        reset = 0; tick = 0; start = '0; pause = '0; abort = '0; auto_reload = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    initial begin
        int n_exp;
        bit seen;
        clear_inputs();
        load_value = '0;
        do_reset();
        check("reset_busy", 32'(busy), 0);
        check("reset_count", 32'(count), 0);

        // 1: reset mid-count
        set_load(0, 5); start[0] = 1; tick = 1;
        step();
        start = '0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (cnt_of(0) == 3) seen = 1; else step();
        end
        check("t1_reach3", 32'(seen), 1);
        reset = 1;
        step();
        reset = 0;
        check("t1_busy", 32'(busy), 0);
        check("t1_count", 32'(count), 0);
        check("t1_expired", 32'(expired), 0);
        check("t1_any", 32'(any_expired), 0);

        // 2: basic countdown with tick every cycle
        do_reset();
        set_load(0, 3); start[0] = 1; tick = 1;
        step();
        start = '0;
        for (int k = 0; k < 4; k++) begin
            check("t2_count", 32'(cnt_of(0)), 32'(3 - k));
            check("t2_busy", 32'(busy[0]), 1);
            check("t2_noexp", 32'(expired[0]), 0);
            step();
        end
        check("t2_expired", 32'(expired[0]), 1);
        check("t2_busy_drop", 32'(busy[0]), 0);
        check("t2_any", 32'(any_expired), 1);
        step();
        check("t2_pulse_end", 32'(expired[0]), 0);

        // 3: pause with sparse ticks
        do_reset();
        set_load(1, 4); start[1] = 1;
        step();
        start = '0;
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (cnt_of(1) == 2) seen = 1;
            else begin tick = (k % 4 == 0); step(); end
        end
        check("t3_reach2", 32'(seen), 1);
        pause[1] = 1;
        for (int k = 0; k < 10; k++) begin
            tick = (k % 4 == 0);
            step();
            check("t3_hold", 32'(cnt_of(1)), 2);
            check("t3_busy", 32'(busy[1]), 1);
        end
        pause[1] = 0;
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick = (k % 4 == 0);
            step();
            if (expired[1]) seen = 1;
        end
        check("t3_expiry_seen", 32'(seen), 1);

        // 4: restart at count 1
        do_reset();
        set_load(2, 3); start[2] = 1; tick = 1;
        step();
        start = '0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (cnt_of(2) == 1) seen = 1; else step();
        end
        check("t4_reach1", 32'(seen), 1);
        set_load(2, 6); start[2] = 1;
        step();
        start = '0;
        check("t4_reload", 32'(cnt_of(2)), 6);
        check("t4_noexp", 32'(expired[2]), 0);
        check("t4_busy", 32'(busy[2]), 1);

        // 5: auto-reload, expiry every 4 cycles, then abort in EXPIRED
        do_reset();
        set_load(3, 2); auto_reload[3] = 1; start[3] = 1; tick = 1;
        step();
        start = '0;
        n_exp = 0;
        for (int k = 2; k <= 12; k++) begin
            step();
            check("t5_period", 32'(expired[3]), 32'(k % 4 == 0));
            if (expired[3]) n_exp++;
        end
        check("t5_count_exp", 32'(n_exp), 3);
        abort[3] = 1;
        step();
        abort = '0;
        check("t5_abort_busy", 32'(busy[3]), 0);
        step();
        check("t5_abort_noexp", 32'(expired[3]), 0);

        // 6: concurrent expiry, abort+start collision
        do_reset();
        set_load(0, 1); set_load(1, 1); start = 4'b0011; tick = 1;
        step();
        start = '0;
        step();
        step();
        check("t6_expired", 32'(expired), 32'h3);
        check("t6_any", 32'(any_expired), 1);
        set_load(0, 7); start[0] = 1;
        step();
        check("t6_started", 32'(busy[0]), 1);
        abort[0] = 1;
        step();
        start = '0; abort = '0;
        check("t6_abort_wins", 32'(busy[0]), 0);
        check("t6_abort_cnt", 32'(cnt_of(0)), 0);

        // Random traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            tick  = ($urandom_range(0, 2) != 0);
            for (int c = 0; c < NUM_CH; c++) begin
                start[c]       = ($urandom_range(0, 11) == 0);
                abort[c]       = ($urandom_range(0, 29) == 0);
                pause[c]       = ($urandom_range(0, 5) == 0);
                auto_reload[c] = ($urandom_range(0, 2) == 0);
                set_load(c, int'($urandom_range(0, (1 << CNT_W) - 1)));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_timer_bank
